// File: rtl/io_tile_pkg.sv
// rtl/io_tile_pkg.sv - shared sizing and config field layout for the parametrised IO tile
// Contents: clog2 with a floor of 1, per-pad config width, chain length,
//           pad/track field offsets within the shadow, pad control bit indices.
package io_tile_pkg;

  // Position of each pad control bit, counted from the end of out_sel.
  localparam int OUT_EN_REL  = 0;
  localparam int OUT_REG_REL = 1;
  localparam int IN_REG_REL  = 2;

  // A select field always has at least one bit, even for a single source.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int pad_w(input int ic_width);
    return clog2_min1(ic_width) + 3;
  endfunction

  function automatic int config_width(input int num_io, input int ic_width);
    return num_io * pad_w(ic_width) + ic_width * clog2_min1(num_io);
  endfunction

  function automatic int pad_off(input int i, input int pw);
    return i * pw;
  endfunction

  function automatic int trk_off(input int j, input int num_io, input int pw, input int sel_io_w);
    return num_io * pw + j * sel_io_w;
  endfunction

  function automatic int out_en_idx(input int sel_ic_w);
    return sel_ic_w + OUT_EN_REL;
  endfunction

  function automatic int out_reg_idx(input int sel_ic_w);
    return sel_ic_w + OUT_REG_REL;
  endfunction

  function automatic int in_reg_idx(input int sel_ic_w);
    return sel_ic_w + IN_REG_REL;
  endfunction

endpackage

// File: rtl/io_tile_config_chain.sv
// rtl/io_tile_config_chain.sv - config shift register with commit shadow and load-complete flag
// Ports: clock, reset (sync, active-high); config_in/config_enable shift one bit;
//        config_commit copies the shift register into shadow; config_out is the
//        chain MSB; config_done flags CONFIG_WIDTH shifts since reset/commit;
//        shadow is the configuration the data paths actually use.
module io_tile_config_chain
  import io_tile_pkg::*;
#(
  parameter int CONFIG_WIDTH = 48
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    config_in,
  input  logic                    config_enable,
  input  logic                    config_commit,
  output logic                    config_out,
  output logic                    config_done,
  output logic [CONFIG_WIDTH-1:0] shadow
);

  localparam int CNT_W = clog2_min1(CONFIG_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIG_WIDTH);

  logic [CONFIG_WIDTH-1:0] sr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_next;

  // A commit restarts the count; a shift in the same cycle is the first
  // bit of the next load, so it starts at one.
  always_comb begin
    count_next = count;
    if (config_commit) begin
      count_next = config_enable ? CNT_W'(1) : '0;
    end else if (config_enable && (count != CNT_MAX)) begin
      count_next = count + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr          <= '0;
      shadow      <= '0;
      count       <= '0;
      config_done <= 1'b0;
    end else begin
      if (config_enable) begin
        sr <= {sr[CONFIG_WIDTH-2:0], config_in};
      end
      // Shadow takes the pre-shift contents when shift and commit coincide.
      if (config_commit) begin
        shadow <= sr;
      end
      count       <= count_next;
      // Flag from the next count so it lines up with the counter itself.
      config_done <= (count_next == CNT_MAX);
    end
  end

  assign config_out = sr[CONFIG_WIDTH-1];

endmodule

// File: rtl/io_tile_param_top.sv
// rtl/io_tile_param_top.sv - perimeter IO tile: config chain plus pad/track muxes and data registers
// Ports: clock, reset (sync, active-high); config_in/config_enable/config_commit
//        drive the config chain, config_out daisy-chains to the next tile,
//        config_done flags a full load; data_from_io/data_to_io face the pads,
//        data_from_ic/data_to_ic face the interconnect tracks.
module io_tile_param_top
  import io_tile_pkg::*;
#(
  parameter int NUM_IO   = 4,
  parameter int IC_WIDTH = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                config_in,
  input  logic                config_enable,
  input  logic                config_commit,
  output logic                config_out,
  output logic                config_done,
  input  logic [NUM_IO-1:0]   data_from_io,
  output logic [NUM_IO-1:0]   data_to_io,
  input  logic [IC_WIDTH-1:0] data_from_ic,
  output logic [IC_WIDTH-1:0] data_to_ic
);

  localparam int SEL_IC_W     = clog2_min1(IC_WIDTH);
  localparam int SEL_IO_W     = clog2_min1(NUM_IO);
  localparam int PAD_W        = pad_w(IC_WIDTH);
  localparam int CONFIG_WIDTH = config_width(NUM_IO, IC_WIDTH);
  localparam int IC_EXT       = 1 << SEL_IC_W;
  localparam int IO_EXT       = 1 << SEL_IO_W;

  logic [CONFIG_WIDTH-1:0] shadow;
  logic [IC_EXT-1:0]       ic_ext;
  logic [IO_EXT-1:0]       p_ext;
  logic [NUM_IO-1:0]       gated;
  logic [NUM_IO-1:0]       pad_in;
  logic [NUM_IO-1:0]       q_out;
  logic [NUM_IO-1:0]       q_in;

  io_tile_config_chain #(
    .CONFIG_WIDTH(CONFIG_WIDTH)
  ) u_chain (
    .clock        (clock),
    .reset        (reset),
    .config_in    (config_in),
    .config_enable(config_enable),
    .config_commit(config_commit),
    .config_out   (config_out),
    .config_done  (config_done),
    .shadow       (shadow)
  );

  // Zero-extend both source buses to the full select range so any
  // out-of-range select reads 0 without a compare.
  always_comb begin
    ic_ext                 = '0;
    ic_ext[IC_WIDTH-1:0]   = data_from_ic;
    p_ext                  = '0;
    p_ext[NUM_IO-1:0]      = pad_in;
  end

  for (genvar i = 0; i < NUM_IO; i++) begin : g_pad
    localparam int OFS = pad_off(i, PAD_W);
    logic [SEL_IC_W-1:0] out_sel;
    logic                out_en;
    logic                out_reg;
    logic                in_reg;

    assign out_sel = shadow[OFS +: SEL_IC_W];
    assign out_en  = shadow[OFS + out_en_idx(SEL_IC_W)];
    assign out_reg = shadow[OFS + out_reg_idx(SEL_IC_W)];
    assign in_reg  = shadow[OFS + in_reg_idx(SEL_IC_W)];

    assign gated[i]      = out_en & ic_ext[out_sel];
    assign data_to_io[i] = out_reg ? q_out[i] : gated[i];
    assign pad_in[i]     = in_reg ? q_in[i] : data_from_io[i];
  end

  for (genvar j = 0; j < IC_WIDTH; j++) begin : g_trk
    localparam int OFS = trk_off(j, NUM_IO, PAD_W, SEL_IO_W);
    assign data_to_ic[j] = p_ext[shadow[OFS +: SEL_IO_W]];
  end

  // Pipeline registers capture every cycle so a registered mode switched
  // on by a commit already holds the commit-cycle value.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_out <= '0;
      q_in  <= '0;
    end else begin
      q_out <= gated;
      q_in  <= data_from_io;
    end
  end

endmodule

// File: tb/tb_io_tile_param_top.sv
// tb/tb_io_tile_param_top.sv - directed self-checking bench for io_tile_param_top
module tb_io_tile_param_top;

  logic       clock;
  logic       reset;
  logic       config_in;
  logic       config_enable;
  logic       config_commit;
  logic       config_out;
  logic       config_done;
  logic [3:0] data_from_io;
  logic [3:0] data_to_io;
  logic [9:0] data_from_ic;
  logic [9:0] data_to_ic;

  logic       b_config_out;
  logic       b_config_done;
  logic [3:0] b_data_to_io;
  logic [9:0] b_data_to_ic;
  logic [3:0] b_data_from_io;
  logic [9:0] b_data_from_ic;

  int tests;
  int fails;

  logic [100:1] sent;

  io_tile_param_top dut (
    .clock        (clock),
    .reset        (reset),
    .config_in    (config_in),
    .config_enable(config_enable),
    .config_commit(config_commit),
    .config_out   (config_out),
    .config_done  (config_done),
    .data_from_io (data_from_io),
    .data_to_io   (data_to_io),
    .data_from_ic (data_from_ic),
    .data_to_ic   (data_to_ic)
  );

  io_tile_param_top dut_b (
    .clock        (clock),
    .reset        (reset),
    .config_in    (config_out),
    .config_enable(config_enable),
    .config_commit(config_commit),
    .config_out   (b_config_out),
    .config_done  (b_config_done),
    .data_from_io (b_data_from_io),
    .data_to_io   (b_data_to_io),
    .data_from_ic (b_data_from_ic),
    .data_to_ic   (b_data_to_ic)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic shift1(input logic b);
    config_in     = b;
    config_enable = 1'b1;
    tick();
    config_enable = 1'b0;
    config_in     = 1'b0;
  endtask

  task automatic load(input logic [47:0] v);
    for (int i = 47; i >= 0; i--) shift1(v[i]);
  endtask

  task automatic commit();
    config_commit = 1'b1;
    tick();
    config_commit = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [47:0] cfg;
    tests          = 0;
    fails          = 0;
    reset          = 1'b1;
    config_in      = 1'b0;
    config_enable  = 1'b0;
    config_commit  = 1'b0;
    data_from_io   = 4'b0101;
    data_from_ic   = 10'h000;
    b_data_from_io = 4'b0000;
    b_data_from_ic = 10'h000;
    tick();
    tick();

    // Reset state
    check("rst_config_out", config_out, 0);
    check("rst_config_done", config_done, 0);
    check("rst_to_io", data_to_io, 0);
    check("rst_to_ic_io0_hi", data_to_ic, 10'h3FF);
    reset = 1'b0;
    data_from_io = 4'b1110;
    #1;
    check("rst_to_ic_io0_lo", data_to_ic, 10'h000);

    // 48 shifts without commit: done only on the 48th, data paths untouched
    data_from_io = 4'b0001;
    data_from_ic = 10'h3FF;
    for (int k = 0; k < 47; k++) shift1(1'b1);
    check("done_at_47", config_done, 0);
    check("cfg_out_at_47", config_out, 0);
    shift1(1'b1);
    check("done_at_48", config_done, 1);
    check("cfg_out_at_48", config_out, 1);
    check("nocommit_to_io", data_to_io, 0);
    check("nocommit_to_ic", data_to_ic, 10'h3FF);

    // pad0 out_sel=3 out_en=1 combinational
    pulse_reset();
    data_from_ic = 10'h008;
    load(48'h13);
    check("precommit_to_io", data_to_io, 0);
    commit();
    check("comb_to_io_hi", data_to_io, 4'b0001);
    check("commit_clears_done", config_done, 0);
    check("comb_to_ic", data_to_ic, 10'h3FF);
    data_from_ic = 10'h000;
    #1;
    check("comb_to_io_lo", data_to_io, 4'b0000);

    // Same with out_reg=1: one cycle of latency
    load(48'h33);
    commit();
    check("reg_after_commit", data_to_io, 4'b0000);
    data_from_ic = 10'h008;
    #1;
    check("reg_hold_lo", data_to_io, 4'b0000);
    tick();
    check("reg_follow_hi", data_to_io, 4'b0001);
    data_from_ic = 10'h000;
    #1;
    check("reg_hold_hi", data_to_io, 4'b0001);
    tick();
    check("reg_follow_lo", data_to_io, 4'b0000);

    // pad1 out_sel=12 out of range, pad2 in_reg, track5 in_sel=2
    cfg = (48'd28 << 7) | (48'd64 << 14) | (48'd2 << 38);
    load(cfg);
    commit();
    data_from_ic = 10'h3FF;
    data_from_io = 4'b0000;
    #1;
    check("oor_sel_to_io", data_to_io, 4'b0000);
    check("trk_idle", data_to_ic, 10'h000);
    tick();
    data_from_io = 4'b0100;
    #1;
    check("trk_reg_lo", data_to_ic, 10'h000);
    tick();
    check("trk_reg_hi", data_to_ic, 10'h020);
    data_from_io = 4'b0000;
    #1;
    check("trk_reg_hold", data_to_ic, 10'h020);
    tick();
    check("trk_reg_back", data_to_ic, 10'h000);

    // Commit together with shift: shadow takes pre-shift contents
    data_from_ic = 10'h008;
    load(48'h13);
    check("shift_keeps_paths", data_to_io, 4'b0000);
    check("done_before_cc", config_done, 1);
    config_commit = 1'b1;
    shift1(1'b1);
    config_commit = 1'b0;
    check("cc_preshift_shadow", data_to_io, 4'b0001);
    check("cc_done", config_done, 0);
    for (int k = 0; k < 46; k++) shift1(1'b0);
    check("cc_done_at_47", config_done, 0);
    shift1(1'b0);
    check("cc_done_at_48", config_done, 1);
    shift1(1'b0);
    shift1(1'b0);
    check("done_saturates", config_done, 1);

    // Two tiles chained: 96-bit latency end to end
    pulse_reset();
    for (int k = 1; k <= 100; k++) sent[k] = ((k % 3) == 0) ^ ((k % 7) == 1);
    for (int n = 1; n <= 100; n++) begin
      shift1(sent[n]);
      if (n == 48) check("chain_a_out_48", config_out, sent[1]);
      if (n >= 96) check($sformatf("chain_b_out_%0d", n), b_config_out, sent[n-95]);
    end

    // Reset in the middle of a shift
    pulse_reset();
    data_from_io = 4'b0000;
    data_from_ic = 10'h008;
    load(48'hFFFF_FFFF_FF93);
    commit();
    check("pre_rst_to_io", data_to_io, 4'b0001);
    for (int k = 0; k < 29; k++) shift1(1'b1);
    check("pre_rst_cfg_out", config_out, 1);
    check("pre_rst_to_io_kept", data_to_io, 4'b0001);
    reset = 1'b1;
    shift1(1'b1);
    reset = 1'b0;
    check("midrst_cfg_out", config_out, 0);
    check("midrst_done", config_done, 0);
    check("midrst_to_io", data_to_io, 4'b0000);
    for (int k = 0; k < 47; k++) shift1(1'b0);
    check("midrst_count_47", config_done, 0);
    shift1(1'b0);
    check("midrst_count_48", config_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
